mdu_iter: RTL and testbench

- Parametrised multiply/divide unit for the execute stage. It sits beside the combinational ALU and owns the HI/LO register pair.
- Multiplies through a configurable-depth pipeline. Divides with an iterative restoring divider, one quotient bit per cycle.
- Uses a ready/valid request handshake, a one-cycle done pulse and a flush input for exceptions and mispredicts.

---
 rtl/mdu_iter_pkg.sv | 27 ++
 rtl/mdu_iter_if.sv | 29 ++
 rtl/mdu_iter_div.sv | 113 +++++++++++
 rtl/mdu_iter.sv | 139 +++++++++++++
 tb/tb_mdu_iter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared types for the multiply/divide unit.
//   mdu_op_t    : operation selector carried on the request bus
//   mdu_state_t : top-level sequencing state
//   WORD_W      : default operand width, word_t is one operand
package mdu_iter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bus of the multiply/divide unit.
//   master : execute stage (drives in_valid, op, a, b, flush)
//   slave  : mdu_iter (drives in_ready, busy, done, hi, lo)
interface mdu_iter_if
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic             in_valid;
  logic             in_ready;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output in_valid, op, a, b, flush,
    input  in_ready, done, hi, lo, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush,
    output in_ready, done, hi, lo, busy
  );
endinterface

// File: rtl/mdu_iter_div.sv
// Restoring divider core, one quotient bit per clock.
//   start     : load operands (magnitudes + sign flags), begin WIDTH iterations
//   abort     : drop the operation in flight (priority over start)
//   signed_op : treat dividend/divisor as two's complement
//   valid     : result available this cycle (one cycle after the last iteration)
//   quotient / remainder : sign-corrected results, valid while valid=1
// Divide by zero yields quotient all ones and remainder = original dividend.
module mdu_iter_div
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    active_d  = active_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;

    a_neg   = signed_op & dividend[WIDTH-1];
    b_neg   = signed_op & divisor[WIDTH-1];
    // Remainder is always below the divisor, so the shifted value fits WIDTH+1
    // bits and diff[WIDTH] is a clean borrow flag.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};

    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d  = 1'b1;
      cnt_d     = CNT_W'(WIDTH);
      rem_d     = '0;
      quo_d     = a_neg ? -dividend : dividend;
      dvs_d     = b_neg ? -divisor : divisor;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      dz_d      = (divisor == '0);
    end else if (active_q) begin
      if (cnt_q != '0) begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  // NOTE: the datapath registers carry no reset; active_q gates their use,
  // so their power-up contents are never observed.
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
  end

  // With a zero divisor every step subtracts nothing: the remainder collects
  // |dividend| and its sign fix restores the original dividend.
  assign valid     = active_q & (cnt_q == '0);
  assign quotient  = dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit owning the HI/LO pair.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mdu_iter_if (request handshake, flush, done, hi, lo)
// One operation in flight: in_ready only in IDLE. MULT/MULTU run through a
// MUL_STAGES-deep product pipeline, DIV/DIVU through mdu_iter_div, MTHI/MTLO
// write directly. done is a registered one-cycle pulse (DONE state).
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int MUL_STAGES = 2,
  parameter int CNT_W      = $clog2(WIDTH + 1)
) (
  input logic        clk,
  input logic        reset,
  mdu_iter_if.slave  bus
);

  mdu_state_t           state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [MUL_STAGES-1:0] mul_vld_q, mul_vld_d;
  logic [2*WIDTH-1:0]   mul_pipe_q [MUL_STAGES];
  logic [2*WIDTH-1:0]   mul_pipe_d [MUL_STAGES];

  logic                 accept;
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   ext_a, ext_b;
  logic                 div_start, div_abort, div_valid;
  logic [WIDTH-1:0]     div_quo, div_rem;

  assign accept     = bus.in_valid & bus.in_ready & ~bus.flush;
  assign mul_signed = (bus.op == MDU_MULT);
  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both forms;
  // the low 2*WIDTH bits are the exact two's complement product.
  assign ext_a      = mul_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign ext_b      = mul_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign div_start  = accept & ((bus.op == MDU_DIV) | (bus.op == MDU_DIVU));
  assign div_abort  = bus.flush & (state_q == DIV);

  mdu_iter_div #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (div_abort),
    .signed_op (bus.op == MDU_DIV),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    mul_pipe_d[0] = ext_a * ext_b;
    mul_vld_d[0]  = 1'b0;
    for (int i = 1; i < MUL_STAGES; i++) begin
      mul_pipe_d[i] = mul_pipe_q[i-1];
      mul_vld_d[i]  = mul_vld_q[i-1];
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.op)
            MDU_MTHI: begin
              hi_d    = bus.a;
              state_d = DONE;
            end
            MDU_MTLO: begin
              lo_d    = bus.a;
              state_d = DONE;
            end
            MDU_MULT, MDU_MULTU: begin
              mul_vld_d[0] = 1'b1;
              state_d      = MUL;
            end
            MDU_DIV, MDU_DIVU: state_d = DIV;
            default: state_d = IDLE;
          endcase
        end
      end
      MUL: begin
        if (bus.flush) begin
          mul_vld_d = '0;
          state_d   = IDLE;
        end else if (mul_vld_q[MUL_STAGES-1]) begin
          {hi_d, lo_d} = mul_pipe_q[MUL_STAGES-1];
          state_d      = DONE;
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (div_valid) begin
          lo_d    = div_quo;
          hi_d    = div_rem;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_vld_q <= mul_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MUL_STAGES; i++) begin
      mul_pipe_q[i] <= mul_pipe_d[i];
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32, MUL_STAGES=2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(
    .WIDTH      (32),
    .MUL_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; in_ready must be high so that edge is t0.
  task automatic issue(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Edges after t0 until done is seen; 100 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(tag, op, a, b);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    step();
    check({tag, "_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    int ready_seen;

    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = MDU_MULT;
    bus.a        = '0;
    bus.b        = '0;
    reset        = 1'b1;
    step();
    step();
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    step();

    // Multiplies: -2*3 signed, 0xFFFFFFFE*3 unsigned.
    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA);

    // Divides: -7/2 = -3 r -1; 100/7 = 14 r 2; overflow; divide by zero.
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("divu_dz", MDU_DIVU, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
    run_op("div_dz_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI then MTLO with in_valid held across both.
    bus.in_valid = 1'b1;
    bus.op       = MDU_MTHI;
    bus.a        = 32'h1234_5678;
    step();
    check("mthi_done", 64'(bus.done), 64'd1);
    check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi_lo_kept", 64'(bus.lo), 64'hFFFF_FFFF);
    check("mthi_busy", 64'(bus.in_ready), 64'd0);
    bus.op = MDU_MTLO;
    bus.a  = 32'h9ABC_DEF0;
    step();
    check("gap_ready", 64'(bus.in_ready), 64'd1);
    check("gap_done", 64'(bus.done), 64'd0);
    step();
    bus.in_valid = 1'b0;
    check("mtlo_done", 64'(bus.done), 64'd1);
    check("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
    step();
    check("mtlo_pulse", 64'(bus.done), 64'd0);

    // Flush a DIV so it is sampled at edge t0+10.
    issue("flush_div", MDU_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = MDU_MTHI;
    bus.a        = 32'hDEAD_BEEF;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'h1234_5678);
    check("flush_lo", 64'(bus.lo), 64'h9ABC_DEF0);
    run_op("after_flush", MDU_MULTU, 32'd7, 32'd6, 2, 32'd0, 32'd42);
    pulses = 0;
    repeat (30) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    check("flush_no_done", 64'(pulses), 64'd0);
    check("flush_hold_lo", 64'(bus.lo), 64'd42);

    // Held in_valid during a DIVU: a single accept, in_ready low throughout.
    bus.in_valid = 1'b1;
    bus.op       = MDU_DIVU;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    check("hold_ready0", 64'(bus.in_ready), 64'd1);
    step();
    lat        = 0;
    ready_seen = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.in_ready === 1'b1) ready_seen++;
      step();
      lat++;
    end
    check("hold_lat", 64'(lat), 64'd33);
    check("hold_ready_seen", 64'(ready_seen), 64'd0);
    check("hold_done_ready", 64'(bus.in_ready), 64'd0);
    check("hold_lo", 64'(bus.lo), 64'd14);
    check("hold_hi", 64'(bus.hi), 64'd2);
    bus.op = MDU_DIV;
    bus.a  = 32'hFFFF_FFF9;
    bus.b  = 32'd2;
    step();
    check("hold_ready_after", 64'(bus.in_ready), 64'd1);
    check("hold_pulse", 64'(bus.done), 64'd0);

    // Second DIV accepted, then reset at t0+5.
    step();
    bus.in_valid = 1'b0;
    check("rst_mid_busy", 64'(bus.in_ready), 64'd0);
    repeat (4) step();
    reset = 1'b1;
    step();
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    check("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    check("rst_mid_no_done", 64'(pulses), 64'd0);
    check("rst_mid_lo_hold", 64'(bus.lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
